// File: rtl/exe_ctrl_pkg.sv
// Shared types and constants for the execute-stage pipeline controller.
// Optional build macro EXE_CTRL_FWD_EN is consumed in exe_ctrl.sv.
package exe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Status register bit positions {N,Z,C,V}
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  // PC register: never a hazard producer
  localparam logic [3:0] R15 = 4'd15;

  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard check of ID sources against up to two producer
// destinations; a producer writing R15 never raises a hazard.
module hazard_detect
  import exe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic       id_two_src,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       p0_valid,
  input  logic [3:0] p0_dest,
  input  logic       p1_valid,
  input  logic [3:0] p1_dest,
  output logic       hazard
);

  function automatic logic src_match(input logic       pv,
                                     input logic [3:0] dest,
                                     input logic       two_src,
                                     input logic [3:0] s1,
                                     input logic [3:0] s2);
    return pv && (dest != R15) && ((s1 == dest) || (two_src && (s2 == dest)));
  endfunction

  logic p0_match;
  logic p1_match;

  assign p0_match = src_match(p0_valid, p0_dest, id_two_src, id_src1, id_src2);
  assign p1_match = src_match(p1_valid, p1_dest, id_two_src, id_src1, id_src2);
  assign hazard   = id_valid && (p0_match || p1_match);

endmodule

// File: rtl/exe_ctrl.sv
// Execute-stage controller: memory-wait FSM, status register, stall/flush/hazard
// priority and sticky wait timeout. Define EXE_CTRL_FWD_EN for load-use-only hazards.
module exe_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_two_src,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       ex_valid,
  input  logic       ex_wb_en,
  input  logic       ex_mem_r_en,
  input  logic       ex_s,
  input  logic       ex_b,
  input  logic [3:0] ex_dest,
  input  logic       mem_valid,
  input  logic       mem_wb_en,
  input  logic       mem_req,
  input  logic [3:0] mem_dest,
  input  logic       cond_pass,
  input  logic [3:0] alu_status,
  input  logic       mem_ready,
  output logic [3:0] sr,
  output logic       freeze_front,
  output logic       bubble_ex,
  output logic       stall_all,
  output logic       branch_taken,
  output logic       flush,
  output logic       wait_timeout,
  output state_t     state_dbg
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] CNT_SAT  = '1;

  state_t                state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic                  ex_prod, mem_prod, hazard, sr_load;
  logic                  unused_cfg;

`ifdef EXE_CTRL_FWD_EN
  // Forwarding covers ALU results; only a load in EXE must stall decode
  assign ex_prod    = ex_valid && ex_wb_en && ex_mem_r_en;
  assign mem_prod   = 1'b0;
  assign unused_cfg = mem_wb_en;
`else
  assign ex_prod    = ex_valid && ex_wb_en;
  assign mem_prod   = mem_valid && mem_wb_en;
  assign unused_cfg = ex_mem_r_en;
`endif

  hazard_detect u_hazard_detect (
    .id_valid   (id_valid),
    .id_two_src (id_two_src),
    .id_src1    (id_src1),
    .id_src2    (id_src2),
    .p0_valid   (ex_prod),
    .p0_dest    (ex_dest),
    .p1_valid   (mem_prod),
    .p1_dest    (mem_dest),
    .hazard     (hazard)
  );

  // Priority: memory stall > taken branch > decode hazard
  assign stall_all    = mem_valid && mem_req && !mem_ready;
  assign branch_taken = ex_valid && ex_b && cond_pass && !stall_all;
  assign flush        = branch_taken;
  assign freeze_front = hazard && !stall_all && !branch_taken;
  assign bubble_ex    = freeze_front;

  // A stalled flag-setting instruction commits once, on its release cycle
  assign sr_load   = ex_valid && ex_s && cond_pass && !stall_all;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (stall_all) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    wait_cnt_next = '0;
    if (state == MEM_WAIT) begin
      wait_cnt_next = (wait_cnt == CNT_SAT) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      sr           <= 4'b0000;
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (sr_load) sr <= alu_status;
      if ((state == MEM_WAIT) && (wait_cnt_next == WAIT_LIM)) wait_timeout <= 1'b1;
    end
  end

endmodule
